mac_unit_packed_pe: RTL and testbench
=====================================

Name: mac_unit_packed_pe

Overview:
Parametrised successor to the packed-weight MAC processing element. Packs LANES signed weights into one multiplier operand and multiplies it by a shared activation. Decodes the packed product into per-lane products with sign correction and accumulates each into its own partial sum. Adds a double-buffered weight register (shadow/active), systolic weight and activation forwarding, and valid-qualified pipelining. Sits as one cell of the systolic MAC array.

Parameters:
ACT_WIDTH, 7, signed activation width
WEIGHT_WIDTH, 7, signed weight width per lane (weights are carried in 8-bit load slots; low WEIGHT_WIDTH bits are used)
LANES, 2, number of weights packed per multiplier; legal values 1 or 2
LANE_SHIFT, 17, bit offset of lane 1 in packed operand; must be >= ACT_WIDTH+WEIGHT_WIDTH (elaboration error otherwise)
PSUM_WIDTH, 24, signed per-lane partial-sum width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
w_load_valid_i  in  1  weight slot valid from upstream PE
w_load_data_i  in  8*LANES  weights, lane k in bits [8k+7:8k]
w_load_valid_o  out  1  registered forward of w_load_valid_i
w_load_data_o  out  8*LANES  registered forward of w_load_data_i
w_swap_i  in  1  promote shadow weights to active
act_valid_i  in  1  activation/psum valid
act_i  in  ACT_WIDTH  signed activation
act_valid_o  out  1  registered forward of act_valid_i
act_o  out  ACT_WIDTH  registered forward of act_i
psum_i  in  PSUM_WIDTH*LANES  incoming partial sums, sampled with act_valid_i
psum_valid_o  out  1  psum_o valid
psum_o  out  PSUM_WIDTH*LANES  outgoing partial sums
shadow_valid_o  out  1  shadow weights loaded and not yet swapped
psum_ovf_o  out  1  sticky overflow flag (only when MAC_PSUM_SAT_EN is defined; tied 0 otherwise)

Behaviour:
- Reset: all outputs and internal registers 0; shadow_valid=0, active_valid=0, pipeline valids cleared. Reset mid-operation discards in-flight data; no psum_valid_o is asserted for those samples.
- Forwarding: w_load_*_o and act_*_o are 1-cycle delays. Data registers update only when the corresponding valid is high; valids update every cycle.
- Weight buffer:
  - w_load_valid_i writes shadow (low WEIGHT_WIDTH bits per lane) and sets shadow_valid.
  - w_swap_i with shadow_valid=1: active<=shadow, packed operand <= sign-extended w0 + (sign-extended w1 <<< LANE_SHIFT), active_valid<=1, shadow_valid<=0.
  - w_swap_i with shadow_valid=0: ignored; active is unchanged.
  - Load and swap in the same cycle: swap takes the old shadow; the new load lands in shadow, and shadow_valid stays 1.
  - Swap takes effect the cycle after assertion. An act_valid_i in the swap cycle uses the old active weights.
- Pipeline (latency 3, throughput 1/cycle, no backpressure):
  - S1: P <= packed_operand * act_i (signed, ACT_WIDTH+LANE_SHIFT+WEIGHT_WIDTH+1 bits); psum_i delayed.
  - S2: decode. lane0 = sign-extend(P[LANE_SHIFT-1:0]); lane1 = (P >>> LANE_SHIFT) + P[LANE_SHIFT-1]. Result is exact for all operand values.
  - S3: psum_o[k] <= psum_k + lane_k, wrapped to PSUM_WIDTH. psum_valid_o = act_valid_i delayed by 3.
- If active_valid=0 the operand is 0: psum passes through unchanged, still valid.
- LANES=1: no packing; the operand is w0, decode is the identity.
- Idle cycles (act_valid_i=0): psum_o holds its last value; psum_valid_o=0.

Optional Feature:
MAC_PSUM_SAT_EN
- Defined: the S3 add saturates each lane to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1]. psum_ovf_o sets on any saturating valid sample and clears only on rst.
- Undefined: two's-complement wrap; psum_ovf_o constant 0.

Test Plan:
- Load w=(3,-2), swap, act=5 with psum=(100,200) -> 3 cycles later psum_o=(115,190), psum_valid_o=1.
- Extremes: w=(-64,63), act=-64, psum=(0,0) -> psum_o=(4096,-4032); also w=(-64,-64), act=-64 -> (4096,4096).
- Swap with shadow_valid=0 -> active unchanged; act=1, psum=(0,0) -> psum_o equals the old weights. Before any swap -> psum_o=psum_i.
- Load (1,1) while swapping shadow (2,2) in the same cycle -> next act=1 yields (2,2); shadow_valid_o=1; second swap then act=1 -> (1,1).
- Back-to-back act stream of 8 samples, then rst asserted for 1 cycle on sample 4 -> no psum_valid_o for samples 2-4 (still in flight, discarded); samples 5-8 emit psum_o=psum_i (weights cleared by rst).
- MAC_PSUM_SAT_EN: psum_i lane0=8388600, w0=63, act=63 -> psum_o lane0=8388607, psum_ovf_o=1 and sticky. Without the macro, lane0 wraps to -8384647.

Source files
------------

// File: rtl/mac_unit_packed_pe.sv
// mac_unit_packed_pe: packed-weight MAC cell with shadow/active weights and systolic forwarding; `define MAC_PSUM_SAT_EN for saturating psums.
module mac_unit_packed_pe #(
    parameter int ACT_WIDTH    = 7,
    parameter int WEIGHT_WIDTH = 7,
    parameter int LANES        = 2,
    parameter int LANE_SHIFT   = 17,
    parameter int PSUM_WIDTH   = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          w_load_valid_i,
    input  logic [8*LANES-1:0]            w_load_data_i,
    output logic                          w_load_valid_o,
    output logic [8*LANES-1:0]            w_load_data_o,
    input  logic                          w_swap_i,
    input  logic                          act_valid_i,
    input  logic [ACT_WIDTH-1:0]          act_i,
    output logic                          act_valid_o,
    output logic [ACT_WIDTH-1:0]          act_o,
    input  logic [PSUM_WIDTH*LANES-1:0]   psum_i,
    output logic                          psum_valid_o,
    output logic [PSUM_WIDTH*LANES-1:0]   psum_o,
    output logic                          shadow_valid_o,
    output logic                          psum_ovf_o
);
    localparam int WW = WEIGHT_WIDTH;
    localparam int PS = PSUM_WIDTH;
    localparam int OW = LANE_SHIFT + WEIGHT_WIDTH + 1;
    localparam int PW = ACT_WIDTH + OW;
    if (LANES != 1 && LANES != 2) begin : g_bad_lanes
        $error("LANES must be 1 or 2");
    end
    if (LANE_SHIFT < ACT_WIDTH + WEIGHT_WIDTH) begin : g_bad_shift
        $error("LANE_SHIFT must be >= ACT_WIDTH+WEIGHT_WIDTH");
    end
    logic [WW*LANES-1:0]     shadow;
    logic                    shadow_valid, active_valid, v1, v2;
    logic signed [OW-1:0]    shadow_op, active_op;
    logic signed [PW-1:0]    prod, p1;
    logic [PS*LANES-1:0]     psum1, psum2, lane_val, lane2, sum_next;
    assign shadow_valid_o = shadow_valid;
    assign prod = PW'(active_valid ? active_op : OW'(0)) * PW'($signed(act_i));
    if (LANES == 2) begin : g_pack
        assign shadow_op = OW'($signed(shadow[WW-1:0])) + (OW'($signed(shadow[2*WW-1:WW])) <<< LANE_SHIFT);
        // lane 0's sign borrowed one from lane 1; the carry-in restores it
        assign lane_val[PS-1:0] = PS'($signed(p1[LANE_SHIFT-1:0]));
        assign lane_val[2*PS-1:PS] = PS'($signed(p1[PW-1:LANE_SHIFT])) + PS'($signed({1'b0, p1[LANE_SHIFT-1]}));
    end else begin : g_single
        assign shadow_op = OW'($signed(shadow[WW-1:0]));
        assign lane_val = PS'(p1);
    end
`ifdef MAC_PSUM_SAT_EN
    logic [LANES-1:0] sat;
`endif
    for (genvar k = 0; k < LANES; k++) begin : g_acc
`ifdef MAC_PSUM_SAT_EN
        logic [PS:0] wide;
        assign wide = {psum2[k*PS+PS-1], psum2[k*PS+:PS]} + {lane2[k*PS+PS-1], lane2[k*PS+:PS]};
        assign sat[k] = wide[PS] ^ wide[PS-1];
        assign sum_next[k*PS+:PS] = sat[k] ? {wide[PS], {(PS-1){~wide[PS]}}} : wide[PS-1:0];
`else
        assign sum_next[k*PS+:PS] = psum2[k*PS+:PS] + lane2[k*PS+:PS];
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            w_load_valid_o <= 1'b0;
            w_load_data_o  <= '0;
            act_valid_o    <= 1'b0;
            act_o          <= '0;
            shadow         <= '0;
            shadow_valid   <= 1'b0;
            active_valid   <= 1'b0;
            active_op      <= '0;
            v1             <= 1'b0;
            v2             <= 1'b0;
            psum_valid_o   <= 1'b0;
            p1             <= '0;
            psum1          <= '0;
            psum2          <= '0;
            lane2          <= '0;
            psum_o         <= '0;
        end else begin
            w_load_valid_o <= w_load_valid_i;
            act_valid_o    <= act_valid_i;
            v1             <= act_valid_i;
            v2             <= v1;
            psum_valid_o   <= v2;
            shadow_valid   <= w_load_valid_i | (shadow_valid & ~w_swap_i);
            if (w_load_valid_i) begin
                w_load_data_o <= w_load_data_i;
                for (int i = 0; i < LANES; i++) shadow[i*WW+:WW] <= w_load_data_i[i*8+:WW];
            end
            if (w_swap_i && shadow_valid) begin
                active_op    <= shadow_op;
                active_valid <= 1'b1;
            end
            if (act_valid_i) begin
                act_o <= act_i;
                p1    <= prod;
                psum1 <= psum_i;
            end
            if (v1) begin
                lane2 <= lane_val;
                psum2 <= psum1;
            end
            if (v2) psum_o <= sum_next;
        end
    end
`ifdef MAC_PSUM_SAT_EN
    always_ff @(posedge clk) psum_ovf_o <= rst ? 1'b0 : (psum_ovf_o | (v2 & |sat));
`else
    assign psum_ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_mac_unit_packed_pe.sv
// tb_mac_unit_packed_pe: directed vectors with a queue scoreboard popped by an output monitor.
module tb_mac_unit_packed_pe;
    localparam int PS = 24;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_load_valid_i = 1'b0, w_load_valid_o, w_swap_i = 1'b0;
    logic [15:0]   w_load_data_i = '0, w_load_data_o;
    logic          act_valid_i = 1'b0, act_valid_o;
    logic [6:0]    act_i = '0, act_o;
    logic [2*PS-1:0] psum_i = '0, psum_o;
    logic          psum_valid_o, shadow_valid_o, psum_ovf_o;
    logic [2*PS-1:0] exp_q[$];
    logic [2*PS-1:0] mon_e;
    int            checks = 0, errors = 0;

    mac_unit_packed_pe dut (
        .clk(clk), .rst(rst),
        .w_load_valid_i(w_load_valid_i), .w_load_data_i(w_load_data_i),
        .w_load_valid_o(w_load_valid_o), .w_load_data_o(w_load_data_o),
        .w_swap_i(w_swap_i),
        .act_valid_i(act_valid_i), .act_i(act_i),
        .act_valid_o(act_valid_o), .act_o(act_o),
        .psum_i(psum_i), .psum_valid_o(psum_valid_o), .psum_o(psum_o),
        .shadow_valid_o(shadow_valid_o), .psum_ovf_o(psum_ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    always @(negedge clk) begin
        if (psum_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL psum_unexpected got %0h required none", psum_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("psum", 64'(psum_o), 64'(mon_e));
            end
        end
    end

    task automatic step(input bit r, input bit wv, input int w0, input int w1, input bit sw,
                        input bit av, input int a, input int p0, input int p1,
                        input bit ex, input int e0, input int e1);
        rst            = r;
        w_load_valid_i = wv;
        w_load_data_i  = {8'(w1), 8'(w0)};
        w_swap_i       = sw;
        act_valid_i    = av;
        act_i          = 7'(a);
        psum_i         = {24'(p1), 24'(p0)};
        if (ex) exp_q.push_back({24'(e1), 24'(e0)});
        @(posedge clk);
        #1;
        rst = 1'b0; w_load_valid_i = 1'b0; w_swap_i = 1'b0; act_valid_i = 1'b0;
    endtask

    task automatic load(input int w0, input int w1);
        step(0, 1, w0, w1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic swap();
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic act(input int a, input int p0, input int p1, input int e0, input int e1);
        step(0, 0, 0, 0, 0, 1, a, p0, p1, 1, e0, e1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_psum_valid", psum_valid_o, 0);
        check("rst_psum", psum_o, 0);
        check("rst_shadow_valid", shadow_valid_o, 0);
        check("rst_act_valid", act_valid_o, 0);
        check("rst_w_valid", w_load_valid_o, 0);
        check("rst_ovf", psum_ovf_o, 0);
        rst = 1'b0;
        act(5, 7, -9, 7, -9);
        load(3, -2);
        check("w_fwd_valid", w_load_valid_o, 1);
        check("w_fwd_data", w_load_data_o, 16'hFE03);
        check("shadow_valid_load", shadow_valid_o, 1);
        swap();
        check("shadow_valid_swap", shadow_valid_o, 0);
        act(5, 100, 200, 115, 190);
        check("act_fwd_valid", act_valid_o, 1);
        check("act_fwd_data", act_o, 5);
        load(-64, 63);
        check("act_fwd_idle", act_valid_o, 0);
        step(0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 3, -2);
        act(-64, 0, 0, 4096, -4032);
        load(-64, -64);
        swap();
        act(-64, 0, 0, 4096, 4096);
        swap();
        act(1, 0, 0, -64, -64);
        load(2, 2);
        step(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("shadow_valid_load_swap", shadow_valid_o, 1);
        act(1, 0, 0, 2, 2);
        swap();
        check("shadow_valid_second_swap", shadow_valid_o, 0);
        act(1, 0, 0, 1, 1);
        idle(4);
        check("idle_valid", psum_valid_o, 0);
        check("idle_hold", psum_o, {24'd1, 24'd1});
        load(63, 0);
        swap();
`ifdef MAC_PSUM_SAT_EN
        act(63, 8388600, 0, 8388607, 0);
        idle(4);
        check("ovf_set", psum_ovf_o, 1);
        act(1, 0, 0, 63, 0);
        idle(4);
        check("ovf_sticky", psum_ovf_o, 1);
`else
        act(63, 8388600, 0, -8384647, 0);
        idle(4);
        check("ovf_tied", psum_ovf_o, 0);
        act(1, 0, 0, 63, 0);
        idle(4);
        check("ovf_tied_after", psum_ovf_o, 0);
`endif
        act(1, 1, 10, 64, 10);
        step(0, 0, 0, 0, 0, 1, 1, 2, 20, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 3, 30, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 4, 40, 0, 0, 0);
        check("rst_mid_shadow", shadow_valid_o, 0);
        check("rst_mid_valid", psum_valid_o, 0);
        for (int k = 5; k <= 8; k++) act(1, k, 10 * k, k, 10 * k);
        idle(6);
        check("queue_empty", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
